// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_arb_pkg
// Description : Shared definitions for the UART transmit arbiter: FSM state
//               encoding, default end-of-line byte and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  // FSM state encoding
  localparam int c_STATE_W = 3;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_IDLE  = 3'd0;  // no owner, waiting for a request
  localparam state_t c_ST_LOAD  = 3'd1;  // TX enable / ready pulse cycle
  localparam state_t c_ST_WBUSY = 3'd2;  // waiting for the UART to go busy
  localparam state_t c_ST_WDONE = 3'd3;  // waiting for the UART to finish
  localparam state_t c_ST_HOLD  = 3'd4;  // line lock held, waiting for owner

  // Byte that terminates a text line
  localparam logic [7:0] c_EOL_DEFAULT = 8'h0A;

  // Counter widths
  localparam int c_IDLE_CNT_W = 16;
  localparam int c_BUSY_CNT_W = 8;

  // Saturating increment for the lock idle counter
  function automatic logic [c_IDLE_CNT_W-1:0] sat_inc(input logic [c_IDLE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the one-hot index
//               of the first valid requester strictly after the pointer,
//               wrapping around, plus an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  winner_o,
  output logic             any_o
);

  int w_best;
  int w_dist [NREQ];

  // Distance of each requester behind the pointer; the smallest valid one wins
  always_comb begin
    w_best   = NREQ;
    winner_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist[i] = (i + NREQ - 1 - int'(ptr_i)) % NREQ;
      if (valid_i[i] && (w_dist[i] < w_best)) begin
        w_best = w_dist[i];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      winner_o[i] = valid_i[i] && (w_dist[i] == w_best);
    end
  end

  assign any_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one serial transmitter between NREQ byte producers.
//               Arbitration is round-robin per text line: a winner keeps the
//               UART until it sends EOL or idles for LOCK_TIMEOUT cycles.
//               Each byte is handed over with a one-cycle enable pulse, then
//               the FSM waits for the transmitter busy flag to rise and fall.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NREQ         = 2,
  parameter int         LOCK_TIMEOUT = 50000,
  parameter logic [7:0] EOL          = c_EOL_DEFAULT,
  parameter int         BUSY_WAIT    = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   grant_o,
  output logic [7:0]        uart_tx_data_o,
  output logic              uart_tx_en_o,
  input  logic              uart_tx_busy_i,
  output logic              err_nobusy_o
);

  localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Last idle count value before the lock is dropped (clamped to counter range)
  localparam logic [c_IDLE_CNT_W-1:0] c_LOCK_LAST =
    (LOCK_TIMEOUT <= 0)                  ? '0 :
    (LOCK_TIMEOUT > (1 << c_IDLE_CNT_W)) ? {c_IDLE_CNT_W{1'b1}} :
                                           c_IDLE_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic c_LOCK_NONE = (LOCK_TIMEOUT == 0);
  localparam logic [c_BUSY_CNT_W-1:0] c_BUSY_LAST =
    (BUSY_WAIT > 0) ? c_BUSY_CNT_W'(BUSY_WAIT - 1) : '0;

  // State and registered outputs
  state_t                  state_q, state_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic [NREQ-1:0]         ready_q, ready_d;
  logic [7:0]              data_q,  data_d;
  logic                    en_q,    en_d;
  logic                    err_q,   err_d;
  logic [c_PTR_W-1:0]      ptr_q,   ptr_d;
  logic [c_IDLE_CNT_W-1:0] idle_q,  idle_d;
  logic [c_BUSY_CNT_W-1:0] bcnt_q,  bcnt_d;

  // Combinational helpers
  logic [NREQ-1:0]    w_winner;
  logic               w_any;
  logic [NREQ-1:0]    w_sel;
  logic [7:0]         w_pick_data;
  logic [c_PTR_W-1:0] w_owner_idx;
  logic               w_owner_valid;
  logic               w_line_done;
  logic               w_idle_expired;
  logic               w_busy_expired;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_PTR_W)
  ) u_rr_pick (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_q),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  // In HOLD only the owner may load; otherwise the round-robin winner does
  assign w_sel = (state_q == c_ST_HOLD) ? grant_q : w_winner;

  // Byte mux driven by the one-hot selection
  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel[i]) begin
        w_pick_data = w_pick_data | req_data_i[8*i +: 8];
      end
    end
  end

  // Binary index of the current owner, becomes the next RR pointer on release
  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        w_owner_idx = c_PTR_W'(i);
      end
    end
  end

  assign w_owner_valid  = |(req_valid_i & grant_q);
  assign w_line_done    = (data_q == EOL) || c_LOCK_NONE;
  assign w_idle_expired = (idle_q == c_LOCK_LAST);
  assign w_busy_expired = (bcnt_q == c_BUSY_LAST);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!uart_tx_busy_i && w_any) begin
          state_d = c_ST_LOAD;
        end
      end
      c_ST_LOAD: begin
        state_d = c_ST_WBUSY;
      end
      c_ST_WBUSY: begin
        if (uart_tx_busy_i || w_busy_expired) begin
          state_d = c_ST_WDONE;
        end
      end
      c_ST_WDONE: begin
        if (!uart_tx_busy_i) begin
          state_d = w_line_done ? c_ST_IDLE : c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (w_owner_valid) begin
          state_d = c_ST_LOAD;
        end else if (w_idle_expired) begin
          state_d = c_ST_IDLE;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values, evaluated on the transition so every output is a flop
  always_comb begin
    grant_d = grant_q;
    ready_d = '0;
    data_d  = data_q;
    en_d    = 1'b0;
    err_d   = err_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!uart_tx_busy_i && w_any) begin
          grant_d = w_winner;
          ready_d = w_winner;
          data_d  = w_pick_data;
          en_d    = 1'b1;
        end
      end
      c_ST_LOAD: begin
        bcnt_d = '0;
      end
      c_ST_WBUSY: begin
        if (!uart_tx_busy_i) begin
          if (w_busy_expired) begin
            err_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      c_ST_WDONE: begin
        if (!uart_tx_busy_i) begin
          if (w_line_done) begin
            ptr_d   = w_owner_idx;
            grant_d = '0;
          end else begin
            idle_d = '0;
          end
        end
      end
      c_ST_HOLD: begin
        if (w_owner_valid) begin
          ready_d = grant_q;
          data_d  = w_pick_data;
          en_d    = 1'b1;
        end else if (w_idle_expired) begin
          ptr_d   = w_owner_idx;
          grant_d = '0;
        end else begin
          idle_d = sat_inc(idle_q);
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Output registers, pointer and counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant_q <= '0;
      ready_q <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= c_PTR_W'(NREQ - 1);
      idle_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      grant_q <= grant_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      en_q    <= en_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign req_ready_o    = ready_q;
  assign grant_o        = grant_q;
  assign uart_tx_data_o = data_q;
  assign uart_tx_en_o   = en_q;
  assign err_nobusy_o   = err_q;

endmodule
`default_nettype wire
